sevenseg_reader: RTL
====================

# sevenseg_reader

Reads a multiplexed seven-segment display bus (segment lines a–g, dp plus four digit enables) and decodes it back into a 16-bit hex value, one digit per enable. It is the receiving end of our seven-segment decoder path: display drivers feed it in loopback for self-check, and it reports a complete frame once all four digits have been seen stable. Invalid segment patterns are flagged rather than silently mapped.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured; legal range 2–255.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a, b, c, d, e, f, g  input  1 each  segment lines, active-high (1 = segment lit).
- dp  input  1  decimal point, active-high.
- an  input  4  digit enables, active-high; an[0] = rightmost digit.
- value  output  16  last complete frame; value[4i+3:4i] = digit i.
- dots  output  4  dp state of each digit in last frame; dots[i] = digit i.
- frame_valid  output  1  one-cycle pulse when value/dots/frame_err update.
- frame_err  output  1  1 if any digit in the reported frame had an invalid pattern.
- frame_count  output  8  number of frames reported, wraps 255 -> 0.

## Operation
- Sample register: {an, a..g, dp} registered every clk edge (12 bits).
- Stability counter: cleared to 0 when the new sample differs from the held sample; otherwise incremented, saturating at STABLE_CYCLES.
- Capture: one capture per stable period, when the counter reaches STABLE_CYCLES, and only if the held an is one-hot. an = 0 (blanking) and multi-hot an never capture.
- Decode, segment order {a,b,c,d,e,f,g}: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Any other pattern, including all-off, is invalid: the digit nibble stores 0 and that digit's invalid flag is set.
- On capture of digit i, update these per-digit registers:
  - nibble[i]
  - dot[i] ← dp
  - inv[i]
  - seen[i] ← 1
- A repeated capture of the same digit before the frame completes overwrites that digit's registers.
- Frame completion: on the edge after seen becomes 4'b1111:
  - value ← {nibble[3..0]}
  - dots ← dot[3..0]
  - frame_err ← |inv
  - frame_valid ← 1
  - frame_count ← frame_count + 1
  - seen and inv cleared
- Outputs value/dots/frame_err hold until the next frame completion.

## Timing
- Reset (asynchronous, rst_n = 0) clears all state: value = 0, dots = 0, frame_valid = 0, frame_err = 0, frame_count = 0. The sample register, stability counter, seen, inv, nibble and dot registers are also cleared. A partial frame is discarded; the first frame after release requires all four digits again.
- Input latency: bus held constant from edge E0 (first edge that registers it) gives a capture at edge E0+STABLE_CYCLES-1, i.e. the digit registers are valid after that edge.
- The completing capture at edge Ec gives value and frame_valid updated at edge Ec+1. The completing digit is included; no bypass is needed, because STABLE_CYCLES ≥ 2 guarantees no new capture lands at Ec+1.
- frame_valid is high for exactly one cycle per frame and never for two consecutive cycles.
- A bus held constant indefinitely captures once only; a new capture requires a change and a new stable period.
- A glitch shorter than STABLE_CYCLES samples causes no capture and restarts the counter.

## Test plan
- Reset: assert rst_n = 0 mid-frame after digits 0–2 captured, release, then drive digit 3 only → no frame_valid; all outputs 0 during and after reset.
- Clean frame, STABLE_CYCLES = 4: cycle an = 0001, 0010, 0100, 1000 with patterns 1111001 (3), 0011111 (b), 1110111 (A), 1001110 (C), each held 8 cycles, dp on digit 1 only → single frame_valid, value = 16'hCAB3, dots = 4'b0010, frame_err = 0, frame_count = 1.
- Latency: hold an = 0001 with pattern 0, one held 4 cycles per digit, check the capture edge against the sample edge → capture at E0+3 and frame_valid the edge after the 4th capture.
- Invalid and blank: digit 2 driven 0000001, later a frame with digit 0 all-off → frame_err = 1 and nibble = 0 in each case; a following clean frame returns frame_err = 0.
- Rejection: a 3-cycle glitch to pattern 8 on digit 1, plus an = 0000 and an = 0011 phases between digits → no capture from any of these; value reflects only stable one-hot digits.
- Wrap: run 256 clean frames → frame_count goes 255 → 0, and frame_valid pulses exactly 256 times.

Source files
------------

// File: rtl/sevenseg_reader.sv
// Seven-segment bus reader: samples {an, a..g, dp}, waits for a stable one-hot
// digit, decodes it and reports a 16-bit frame once all four digits are seen.

module sevenseg_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap_i,
  input  logic       clr_i,
  input  logic [3:0] nib_i,
  input  logic       dot_i,
  input  logic       inv_i,
  output logic [3:0] nib_o,
  output logic       dot_o,
  output logic       inv_o,
  output logic       seen_o
);
  logic [3:0] nib_q;
  logic       dot_q, inv_q, seen_q;

  // A capture and a frame clear never share an edge; capture wins if they did.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q  <= '0;
      dot_q  <= 1'b0;
      inv_q  <= 1'b0;
      seen_q <= 1'b0;
    end else if (cap_i) begin
      nib_q  <= nib_i;
      dot_q  <= dot_i;
      inv_q  <= inv_i;
      seen_q <= 1'b1;
    end else if (clr_i) begin
      inv_q  <= 1'b0;
      seen_q <= 1'b0;
    end
  end

  assign nib_o  = nib_q;
  assign dot_o  = dot_q;
  assign inv_o  = inv_q;
  assign seen_o = seen_q;
endmodule

module sevenseg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  dots,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  frame_count
);
  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);
  // The first sample of a run is not counted, so STABLE_CYCLES identical
  // samples means the counter is stepping to STABLE_CYCLES-1.
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);

  logic [11:0] samp_d, samp_q;
  logic [7:0]  cnt_d, cnt_q;
  logic        same, onehot, capture;
  logic [3:0]  held_an;
  logic [6:0]  held_seg;
  logic [4:0]  dec;

  logic [NUM_DIGITS-1:0][3:0] nib;
  logic [NUM_DIGITS-1:0]      dot, inv, seen, cap;
  logic                       frame_done;

  logic [15:0] value_q;
  logic [3:0]  dots_q;
  logic        fv_q, ferr_q;
  logic [7:0]  fcnt_q;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 5'h00;
      7'b0110000: decode = 5'h01;
      7'b1101101: decode = 5'h02;
      7'b1111001: decode = 5'h03;
      7'b0110011: decode = 5'h04;
      7'b1011011: decode = 5'h05;
      7'b1011111: decode = 5'h06;
      7'b1110000: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1111011: decode = 5'h09;
      7'b1110111: decode = 5'h0A;
      7'b0011111: decode = 5'h0B;
      7'b1001110: decode = 5'h0C;
      7'b0111101: decode = 5'h0D;
      7'b1001111: decode = 5'h0E;
      7'b1000111: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  assign samp_d   = {an, a, b, c, d, e, f, g, dp};
  assign same     = (samp_d == samp_q);
  assign held_an  = samp_q[11:8];
  assign held_seg = samp_q[7:1];
  assign onehot   = (held_an != 4'd0) && ((held_an & (held_an - 4'd1)) == 4'd0);
  assign capture  = same && (cnt_q == CNT_CAP) && onehot;
  assign dec      = decode(held_seg);
  assign cap      = capture ? held_an : '0;
  assign frame_done = &seen;

  always_comb begin
    cnt_d = cnt_q;
    if (!same)                 cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 8'd1;
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    sevenseg_digit u_dig (
      .clk    (clk),
      .rst_n  (rst_n),
      .cap_i  (cap[i]),
      .clr_i  (frame_done),
      .nib_i  (dec[3:0]),
      .dot_i  (samp_q[0]),
      .inv_i  (dec[4]),
      .nib_o  (nib[i]),
      .dot_o  (dot[i]),
      .inv_o  (inv[i]),
      .seen_o (seen[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q  <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      dots_q  <= '0;
      fv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      samp_q <= samp_d;
      cnt_q  <= cnt_d;
      fv_q   <= frame_done;
      if (frame_done) begin
        value_q <= nib;
        dots_q  <= dot;
        ferr_q  <= |inv;
        fcnt_q  <= fcnt_q + 8'd1;
      end
    end
  end

  assign value       = value_q;
  assign dots        = dots_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign frame_count = fcnt_q;
endmodule
